resp_misr: RTL and testbench
============================

RESP_MISR -- requirements
Module: resp_misr

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; no other clock or asynchronous input SHALL exist.
REQ-002 Parameter SEED, default 16'hFFFF, SHALL be the signature start value.
REQ-003 Parameter POLY, default 16'h1021, SHALL be the MISR feedback polynomial (x^16+x^12+x^5+1).
REQ-004 Parameter TIMEOUT, default 255, SHALL be the number of consecutive RUN cycles without an accepted response before aborting.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 start  input  1  one-cycle request to begin a compaction run.
REQ-008 abort  input  1  cancels a run in progress.
REQ-009 n_patterns  input  16  number of responses to compact, sampled on an accepted start.
REQ-010 golden  input  16  expected signature, compared in DONE.
REQ-011 resp_valid  input  1  8-bit response from the upstream combinational stage is valid.
REQ-012 resp  input  8  response word (the 8 outputs of the upstream combinational stage, bit 0 first).
REQ-013 resp_ready  output  1  block accepts resp this cycle.
REQ-014 busy  output  1  high while in RUN.
REQ-015 done  output  1  high while in DONE.
REQ-016 pass  output  1  signature==golden; meaningful only while done=1.
REQ-017 timeout  output  1  last run ended by TIMEOUT.
REQ-018 signature  output  16  current MISR value.
REQ-019 count  output  16  responses accepted in the current or last run.

Function
REQ-020 The FSM SHALL have three states, IDLE, RUN and DONE, with state, signature, count, the idle counter and timeout all registered.
REQ-021 resp_ready SHALL equal (state==RUN) and SHALL be decoded from state only, with no combinational path from resp_valid.
REQ-022 A response SHALL be accepted when resp_valid and resp_ready are high in the same cycle.
REQ-023 On acceptance: signature <= {sig[14:0],0} ^ (sig[15] ? POLY : 0) ^ {8'h00,resp}; count <= count+1.
REQ-024 IDLE->RUN SHALL occur on start with n_patterns!=0; in that cycle the block SHALL set signature<=SEED, count<=0, idle counter<=0, timeout<=0, and latch n_patterns.
REQ-025 IDLE->DONE SHALL occur on start with n_patterns==0, with signature<=SEED, count<=0 and timeout<=0.
REQ-026 RUN->DONE SHALL occur in the cycle after the acceptance that makes count equal the latched n_patterns; no further acceptance SHALL occur.
REQ-027 In RUN, the idle counter SHALL increment on each cycle without acceptance and clear on acceptance.
REQ-028 When the idle counter would reach TIMEOUT, the block SHALL go to DONE with timeout<=1.
REQ-029 In RUN, abort SHALL send the FSM to IDLE and leave signature and count frozen, with done=0 and timeout unchanged.
REQ-030 If abort and an acceptance occur in the same cycle, abort SHALL win and the response SHALL be discarded.
REQ-031 In RUN, start SHALL be ignored.
REQ-032 In DONE, outputs SHALL hold, and start SHALL restart exactly as from IDLE (REQ-024/025).
REQ-033 In DONE, abort SHALL return the FSM to IDLE.
REQ-034 pass SHALL be combinational (signature==golden) gated by done.
REQ-035 count SHALL saturate at 16'hFFFF and SHALL never wrap; it cannot exceed n_patterns in any case.
REQ-036 busy and done SHALL never both be high.

Reset
REQ-037 On rst=1 at a clock edge: state=IDLE, signature=SEED, count=0, idle counter=0, timeout=0; hence resp_ready=0, busy=0, done=0, pass=0.
REQ-038 rst SHALL override start, abort and acceptance in the same cycle, including reset asserted mid-RUN.

Verification
REQ-039 Scenario: rst; start with n_patterns=1; resp=8'hA5 valid -> signature=16'hEF7A, count=1, done=1 next cycle; with golden=16'hEF7A, pass=1.
REQ-040 Scenario: n_patterns=2, resp 8'h00 twice -> signature after 1st=16'hEFDF, after 2nd=16'hCF9F; resp_valid held high afterwards -> resp_ready=0 in DONE, no third acceptance.
REQ-041 Scenario: start with n_patterns=0 -> done=1 the next cycle, signature=16'hFFFF, count=0; golden=16'h0000 -> pass=0.
REQ-042 Scenario: n_patterns=4, two accepts, then resp_valid=0 for TIMEOUT cycles -> done=1, timeout=1, count=2; a new start clears timeout.
REQ-043 Scenario: mid-RUN, abort coincident with a valid response -> IDLE, count unchanged, response not compacted; separately, rst mid-RUN -> all outputs at REQ-037 values next cycle.
REQ-044 Scenario: random valid stalls against a reference model over 1000 patterns -> signature and count match the model every cycle, and resp_ready never depends on resp_valid.

Source files
------------

// File: rtl/resp_misr.sv
// rtl/resp_misr.sv - 16-bit MISR compactor for 8-bit responses with run/timeout/abort control
module resp_misr #(
  parameter logic [15:0] SEED    = 16'hFFFF,
  parameter logic [15:0] POLY    = 16'h1021,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] n_patterns,
  input  logic [15:0] golden,
  input  logic        resp_valid,
  input  logic [7:0]  resp,
  output logic        resp_ready,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] signature,
  output logic [15:0] count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q, state_nx;
  logic [15:0] sig_q, sig_nx;
  logic [15:0] count_q, count_nx;
  logic [15:0] n_q, n_nx;
  logic [31:0] idle_q, idle_nx;
  logic        to_q, to_nx;

  logic        accept;
  logic [15:0] sig_step;
  logic [15:0] count_inc;
  logic [31:0] idle_inc;

  // Ready comes from state alone so upstream valid can never loop back into it.
  assign resp_ready = (state_q == RUN);
  assign accept     = resp_valid && resp_ready;

  // One MISR shift: Galois feedback on the MSB, response folded into the low byte.
  assign sig_step  = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? POLY : 16'h0000) ^ {8'h00, resp};
  assign count_inc = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
  assign idle_inc  = idle_q + 32'd1;

  // Next-state and datapath decode; abort beats a coincident acceptance.
  always_comb begin
    state_nx = state_q;
    sig_nx   = sig_q;
    count_nx = count_q;
    n_nx     = n_q;
    idle_nx  = idle_q;
    to_nx    = to_q;
    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE && abort) begin
          state_nx = IDLE;
        end else if (start) begin
          sig_nx   = SEED;
          count_nx = 16'd0;
          idle_nx  = 32'd0;
          to_nx    = 1'b0;
          n_nx     = n_patterns;
          state_nx = (n_patterns == 16'd0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_nx = IDLE;
        end else if (accept) begin
          sig_nx   = sig_step;
          count_nx = count_inc;
          idle_nx  = 32'd0;
          if (count_inc == n_q) begin
            state_nx = DONE;
          end
        end else if (idle_inc >= TIMEOUT) begin
          state_nx = DONE;
          to_nx    = 1'b1;
        end else begin
          idle_nx = idle_inc;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State and datapath registers; reset overrides every other request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      count_q <= 16'd0;
      n_q     <= 16'd0;
      idle_q  <= 32'd0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_nx;
      sig_q   <= sig_nx;
      count_q <= count_nx;
      n_q     <= n_nx;
      idle_q  <= idle_nx;
      to_q    <= to_nx;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pass      = done && (sig_q == golden);
  assign timeout   = to_q;
  assign signature = sig_q;
  assign count     = count_q;

endmodule

// File: tb/tb_resp_misr.sv
// tb/tb_resp_misr.sv - directed and random scoreboard bench for resp_misr
module tb_resp_misr;

  localparam int TO = 255;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] n_patterns = 16'd0;
  logic [15:0] golden = 16'd0;
  logic        resp_valid = 1'b0;
  logic [7:0]  resp = 8'd0;
  logic        resp_ready;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [15:0] signature;
  logic [15:0] count;

  int n_checks = 0;
  int n_errors = 0;

  int          m_state = S_IDLE;
  logic [15:0] m_sig = 16'hFFFF;
  logic [15:0] m_cnt = 16'd0;
  logic [15:0] m_n = 16'd0;
  int          m_idle = 0;
  logic        m_to = 1'b0;
  logic [31:0] sb_q[$];

  resp_misr #(.SEED(16'hFFFF), .POLY(16'h1021), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .n_patterns(n_patterns), .golden(golden),
    .resp_valid(resp_valid), .resp(resp), .resp_ready(resp_ready),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .signature(signature), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [7:0] d);
    logic [15:0] r;
    r = s << 1;
    if (s[15]) r = r ^ 16'h1021;
    return r ^ {8'h00, d};
  endfunction

  task automatic model_update();
    if (rst) begin
      m_state = S_IDLE; m_sig = 16'hFFFF; m_cnt = 16'd0; m_idle = 0; m_to = 1'b0;
    end else if (m_state == S_RUN) begin
      if (abort) begin
        m_state = S_IDLE;
      end else if (resp_valid) begin
        m_sig = misr(m_sig, resp);
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_idle = 0;
        sb_q.push_back({m_sig, m_cnt});
        if (m_cnt == m_n) m_state = S_DONE;
      end else if (m_idle + 1 >= TO) begin
        m_state = S_DONE; m_to = 1'b1;
      end else begin
        m_idle++;
      end
    end else if (m_state == S_DONE && abort) begin
      m_state = S_IDLE;
    end else if (start) begin
      m_sig = 16'hFFFF; m_cnt = 16'd0; m_idle = 0; m_to = 1'b0; m_n = n_patterns;
      m_state = (n_patterns == 16'd0) ? S_DONE : S_RUN;
    end
  endtask

  // One clock: probe ready independence, predict, clock, then score and compare.
  task automatic step();
    logic rdy_a, rdy_b, acc_dut;
    logic [31:0] e;
    rdy_a = resp_ready;
    resp_valid = ~resp_valid; #1;
    rdy_b = resp_ready;
    resp_valid = ~resp_valid; #1;
    chk("ready_indep", {31'd0, rdy_b}, {31'd0, rdy_a});
    acc_dut = resp_valid && resp_ready && !abort && !rst;
    model_update();
    @(posedge clk); #1;
    if (acc_dut) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_accept", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_sig", {16'd0, signature}, {16'd0, e[31:16]});
        chk("sb_cnt", {16'd0, count}, {16'd0, e[15:0]});
      end
    end
    chk("m_ready", {31'd0, resp_ready}, {31'd0, m_state == S_RUN});
    chk("m_busy", {31'd0, busy}, {31'd0, m_state == S_RUN});
    chk("m_done", {31'd0, done}, {31'd0, m_state == S_DONE});
    chk("m_timeout", {31'd0, timeout}, {31'd0, m_to});
    chk("m_sig", {16'd0, signature}, {16'd0, m_sig});
    chk("m_cnt", {16'd0, count}, {16'd0, m_cnt});
    chk("m_pass", {31'd0, pass}, {31'd0, (m_state == S_DONE) && (m_sig == golden)});
  endtask

  initial begin
    logic [15:0] saved_sig;
    int guard;
    @(posedge clk); #1;

    // reset state
    rst = 1'b1; start = 1'b1; step(); rst = 1'b0; start = 1'b0;
    chk("rst_ready", {31'd0, resp_ready}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_sig", {16'd0, signature}, 32'h0000FFFF);
    chk("rst_cnt", {16'd0, count}, 32'd0);

    // single pattern A5
    golden = 16'hEF7A; n_patterns = 16'd1; start = 1'b1; step(); start = 1'b0;
    chk("a5_busy", {31'd0, busy}, 32'd1);
    resp_valid = 1'b1; resp = 8'hA5; step(); resp_valid = 1'b0;
    chk("a5_sig", {16'd0, signature}, 32'h0000EF7A);
    chk("a5_cnt", {16'd0, count}, 32'd1);
    chk("a5_done", {31'd0, done}, 32'd1);
    chk("a5_pass", {31'd0, pass}, 32'd1);

    // two zero responses, then valid held in DONE
    golden = 16'h0000; n_patterns = 16'd2; start = 1'b1; step(); start = 1'b0;
    resp_valid = 1'b1; resp = 8'h00; step();
    chk("z1_sig", {16'd0, signature}, 32'h0000EFDF);
    chk("z1_done", {31'd0, done}, 32'd0);
    step();
    chk("z2_sig", {16'd0, signature}, 32'h0000CF9F);
    chk("z2_done", {31'd0, done}, 32'd1);
    step();
    chk("z3_ready", {31'd0, resp_ready}, 32'd0);
    chk("z3_cnt", {16'd0, count}, 32'd2);
    chk("z3_sig", {16'd0, signature}, 32'h0000CF9F);
    resp_valid = 1'b0;

    // zero patterns
    golden = 16'h0000; n_patterns = 16'd0; start = 1'b1; step(); start = 1'b0;
    chk("n0_done", {31'd0, done}, 32'd1);
    chk("n0_sig", {16'd0, signature}, 32'h0000FFFF);
    chk("n0_cnt", {16'd0, count}, 32'd0);
    chk("n0_pass", {31'd0, pass}, 32'd0);

    // timeout after two accepts
    n_patterns = 16'd4; start = 1'b1; step(); start = 1'b0;
    resp_valid = 1'b1; resp = 8'h5A; step(); resp = 8'hC3; step(); resp_valid = 1'b0;
    for (int i = 0; i < TO - 1; i++) step();
    chk("to_pre_busy", {31'd0, busy}, 32'd1);
    chk("to_pre_timeout", {31'd0, timeout}, 32'd0);
    step();
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_timeout", {31'd0, timeout}, 32'd1);
    chk("to_cnt", {16'd0, count}, 32'd2);
    n_patterns = 16'd4; start = 1'b1; step(); start = 1'b0;
    chk("to_clear", {31'd0, timeout}, 32'd0);
    chk("to_restart_busy", {31'd0, busy}, 32'd1);

    // abort coincident with a valid response
    resp_valid = 1'b1; resp = 8'h11; step();
    saved_sig = misr(16'hFFFF, 8'h11);
    chk("ab_pre_cnt", {16'd0, count}, 32'd1);
    abort = 1'b1; resp = 8'h3C; step(); abort = 1'b0; resp_valid = 1'b0;
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_done", {31'd0, done}, 32'd0);
    chk("ab_cnt", {16'd0, count}, 32'd1);
    chk("ab_sig", {16'd0, signature}, {16'd0, saved_sig});

    // reset mid-run with a valid response present
    n_patterns = 16'd4; start = 1'b1; step(); start = 1'b0;
    resp_valid = 1'b1; resp = 8'h77; step();
    rst = 1'b1; step(); rst = 1'b0; resp_valid = 1'b0;
    chk("mr_ready", {31'd0, resp_ready}, 32'd0);
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_done", {31'd0, done}, 32'd0);
    chk("mr_sig", {16'd0, signature}, 32'h0000FFFF);
    chk("mr_cnt", {16'd0, count}, 32'd0);

    // random stalls over 1000 patterns
    golden = 16'h0000; n_patterns = 16'd1000; start = 1'b1; step(); start = 1'b0;
    guard = 0;
    while (m_state == S_RUN && guard < 5000) begin
      resp_valid = ($urandom_range(0, 3) != 0);
      resp = 8'($urandom);
      step();
      guard++;
    end
    resp_valid = 1'b0;
    chk("rnd_bounded", {31'd0, guard < 5000}, 32'd1);
    chk("rnd_done", {31'd0, done}, 32'd1);
    chk("rnd_cnt", {16'd0, count}, 32'd1000);
    chk("rnd_timeout", {31'd0, timeout}, 32'd0);
    golden = m_sig; #1;
    chk("rnd_pass", {31'd0, pass}, 32'd1);
    chk("sb_drained", sb_q.size(), 32'd0);

    // abort from DONE returns to IDLE
    abort = 1'b1; step(); abort = 1'b0;
    chk("dab_done", {31'd0, done}, 32'd0);
    chk("dab_busy", {31'd0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
